ysyx_23060124_mdu: RTL and testbench

YSYX_23060124_MDU -- requirements
Module: ysyx_23060124_mdu

---
 rtl/ysyx_23060124_mdu.sv | 158 +++++++++++++++
 tb/tb_ysyx_23060124_mdu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_mdu.sv
// Iterative RV-M multiply/divide unit.
// Uses radix-2 shift-add multiplication and restoring division on operand magnitudes.
// Signs are fixed up when the last iteration completes.
// Divide-by-zero and signed overflow skip the iteration entirely.
module ysyx_23060124_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     opnd_b;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 neg_main;
    logic                 neg_rem;
    logic [WIDTH-1:0]     res_q;
    logic [WIDTH-1:0]     calc_res;

    logic                 accept;
    logic                 src1_signed;
    logic                 src2_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 div_zero;
    logic                 div_ovf;
    logic                 special;
    logic [WIDTH-1:0]     special_res;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   prod_fin;
    logic [WIDTH-1:0]     quo_fin;
    logic [WIDTH-1:0]     rem_fin;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign res       = out_valid ? res_q : '0;

    // A flush in the same cycle drops the incoming request.
    assign accept = in_valid && in_ready && !flush;

    // Decode the operand signedness for the request and detect the early-out cases.
    always_comb begin
        src1_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        src2_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg       = src1_signed && src1[WIDTH-1];
        b_neg       = src2_signed && src2[WIDTH-1];
        a_mag       = a_neg ? -src1 : src1;
        b_mag       = b_neg ? -src2 : src2;
        div_zero    = op[2] && (src2 == '0);
        div_ovf     = ((op == 3'b100) || (op == 3'b110)) && (src1 == MOST_NEG) && (src2 == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? src1 : '1;
        end else if (div_ovf) begin
            special_res = op[1] ? '0 : src1;
        end
    end

    // Compute one shift-add or restoring-subtract step and the sign-corrected result of that step.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd_b : '0)};
        trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_b};
        if (op_q[2]) begin
            acc_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
        prod_fin = neg_main ? -acc_next : acc_next;
        quo_fin  = neg_main ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem_fin  = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
        if (op_q[2]) begin
            calc_res = op_q[1] ? rem_fin : quo_fin;
        end else begin
            calc_res = (op_q[1:0] == 2'b00) ? prod_fin[WIDTH-1:0] : prod_fin[2*WIDTH-1:WIDTH];
        end
    end

    // Register the state; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Compute the next state; flush wins over out_ready.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: if (flush || out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the request on accept, step the datapath in CALC, and capture the final result.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= '0;
            opnd_b   <= '0;
            acc      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            res_q    <= '0;
        end else if (accept) begin
            cnt      <= '0;
            op_q     <= op;
            opnd_b   <= b_mag;
            acc      <= {{WIDTH{1'b0}}, a_mag};
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            res_q    <= special ? special_res : '0;
        end else if ((state == CALC) && !flush) begin
            acc <= acc_next;
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt == LAST) begin
                res_q <= calc_res;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060124_mdu.sv
// Directed testbench for the iterative multiply/divide unit.
// Covers a 32-bit instance and a 16-bit instance.
module tb_ysyx_23060124_mdu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        busy;

    logic        h_in_valid;
    logic        h_in_ready;
    logic [2:0]  h_op;
    logic [15:0] h_src1;
    logic [15:0] h_src2;
    logic        h_flush;
    logic        h_out_valid;
    logic        h_out_ready;
    logic [15:0] h_res;
    logic        h_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Free-running clock with a 10-unit period.
    always #5 clock = ~clock;

    ysyx_23060124_mdu #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .busy(busy)
    );

    ysyx_23060124_mdu #(.WIDTH(16), .CNT_W(5)) dut16 (
        .clock(clock), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op(h_op), .src1(h_src1), .src2(h_src2), .flush(h_flush), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .res(h_res), .busy(h_busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request and hold it until accepted, then scramble the inputs.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        op       = o;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        op       = 3'($urandom_range(0, 7));
        src1     = $urandom();
        src2     = $urandom();
    endtask

    // Count cycles from accept until out_valid; lat = 1 means the first cycle after accept.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; op = 3'b000; src1 = '0; src2 = '0; flush = 1'b0; out_ready = 1'b0;
        h_in_valid = 1'b0; h_op = 3'b000; h_src1 = '0; h_src2 = '0; h_flush = 1'b0; h_out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_res: got %h expected 0", res); end
    endtask

    task automatic test_mul();
        logic [2:0]  t_op  [5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b010};
        logic [31:0] t_a   [5] = '{32'h7, 32'h7, 32'h7, 32'h7, 32'hFFFF_FFFD};
        logic [31:0] t_b   [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h7};
        logic [31:0] t_exp [5] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h6, 32'h6, 32'hFFFF_FFFF};
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_op(t_op[i], t_a[i], t_b[i]);
            wait_valid(lat);
            n_cmp++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL mul_latency[%0d]: got %0d expected 33", i, lat); end
            n_cmp++; if (res !== t_exp[i]) begin n_fail++; $display("[TB] FAIL mul_res[%0d]: got %h expected %h", i, res, t_exp[i]); end
            consume();
        end
    endtask

    task automatic test_div();
        logic [2:0]  t_op  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] t_a   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] t_exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(t_op[i], t_a[i], 32'h2);
            wait_valid(lat);
            n_cmp++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
            n_cmp++; if (res !== t_exp[i]) begin n_fail++; $display("[TB] FAIL div_res[%0d]: got %h expected %h", i, res, t_exp[i]); end
            consume();
        end
    endtask

    task automatic test_special();
        logic [2:0]  t_op  [5] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100};
        logic [31:0] t_a   [5] = '{32'h5, 32'h5, 32'h8000_0000, 32'h8000_0000, 32'h5};
        logic [31:0] t_b   [5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] t_exp [5] = '{32'hFFFF_FFFF, 32'h5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_op(t_op[i], t_a[i], t_b[i]);
            wait_valid(lat);
            n_cmp++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL special_latency[%0d]: got %0d expected 1", i, lat); end
            n_cmp++; if (res !== t_exp[i]) begin n_fail++; $display("[TB] FAIL special_res[%0d]: got %h expected %h", i, res, t_exp[i]); end
            consume();
        end
    endtask

    task automatic test_hold();
        int lat;
        start_op(3'b000, 32'd3, 32'd5);
        wait_valid(lat);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL hold_latency: got %0d expected 33", lat); end
        in_valid = 1'b1; op = 3'b011; src1 = 32'd9; src2 = 32'd9;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", i, out_valid); end
            n_cmp++; if (res !== 32'd15) begin n_fail++; $display("[TB] FAIL hold_res[%0d]: got %h expected f", i, res); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL release_valid: got %b expected 0", out_valid); end
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL release_res: got %h expected 0", res); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL no_same_cycle_accept: busy %b expected 0", busy); end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        start_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (12) tick();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_pre_busy: got %b expected 1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_calc_busy: got %b expected 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_calc_in_ready: got %b expected 1", in_ready); end
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen = 1;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL flush_calc_no_valid: got %0d expected 0", seen); end
        start_op(3'b000, 32'd3, 32'd4);
        wait_valid(lat);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL post_flush_latency: got %0d expected 33", lat); end
        n_cmp++; if (res !== 32'd12) begin n_fail++; $display("[TB] FAIL post_flush_res: got %h expected c", res); end
        consume();
        // Flush in DONE, coinciding with out_ready, discards the result.
        start_op(3'b000, 32'd2, 32'd2);
        wait_valid(lat);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_done_valid: got %b expected 0", out_valid); end
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL flush_done_res: got %h expected 0", res); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_done_in_ready: got %b expected 1", in_ready); end
        // A request coinciding with flush in IDLE is dropped.
        flush = 1'b1; in_valid = 1'b1; op = 3'b101; src1 = 32'd5; src2 = 32'd0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_idle_drop: busy %b expected 0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_idle_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int seen;
        start_op(3'b000, 32'd7, 32'd3);
        repeat (5) tick();
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL midreset_res: got %h expected 0", res); end
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen = 1;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL midreset_no_valid: got %0d expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  t_op  [6] = '{3'b100, 3'b110, 3'b110, 3'b000, 3'b001, 3'b101};
        logic [31:0] t_a   [6] = '{32'h64, 32'h64, 32'hFFFF_FF9C, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000};
        logic [31:0] t_b   [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h7, 32'h10, 32'h10, 32'hFFFF_FFFF};
        logic [31:0] t_exp [6] = '{32'hFFFF_FFF2, 32'h2, 32'hFFFF_FFFE, 32'h2345_6780, 32'h1, 32'h0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            start_op(t_op[i], t_a[i], t_b[i]);
            wait_valid(lat);
            n_cmp++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected 33", i, lat); end
            n_cmp++; if (res !== t_exp[i]) begin n_fail++; $display("[TB] FAIL b2b_res[%0d]: got %h expected %h", i, res, t_exp[i]); end
            consume();
        end
    endtask

    task automatic test_width16();
        int lat;
        h_op = 3'b011; h_src1 = 16'hFFFF; h_src2 = 16'hFFFF; h_in_valid = 1'b1;
        n_cmp++; if (h_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL w16_in_ready: got %b expected 1", h_in_ready); end
        tick();
        h_in_valid = 1'b0; h_src1 = 16'h0; h_src2 = 16'h0;
        lat = 1;
        while (!h_out_valid && lat < 100) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat !== 17) begin n_fail++; $display("[TB] FAIL w16_latency: got %0d expected 17", lat); end
        n_cmp++; if (h_res !== 16'hFFFE) begin n_fail++; $display("[TB] FAIL w16_res: got %h expected fffe", h_res); end
        h_out_ready = 1'b1;
        tick();
        h_out_ready = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_hold();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_width16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
